// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: boot-time loader for the instruction RAM (write port 0).
// Takes words from a valid/ready stream and writes them to base_addr onward.
// Holds the core in reset (cpu_run=0) until exactly load_len words are stored.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, abort      begin a load / cancel a load in progress
//   base_addr         first write address, latched on start
//   load_len          number of words, latched on start
//   s_valid, s_data   input word stream
//   s_ready           stream handshake back to the source
//   mem_cs, mem_we    RAM port-0 strobes (registered)
//   mem_addr          RAM port-0 address (registered)
//   mem_data          RAM port-0 write data (registered)
//   load_busy         loading in progress
//   load_done         load finished
//   load_err          load failed (zero length, abort or timeout)
//   cpu_run           core release, high only once the load is done
//   words_loaded      words accepted in the current/last load
module imem_load_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] load_len,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_err,
  output logic                  cpu_run,
  output logic [ADDR_WIDTH-1:0] words_loaded
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE,
    S_ERR
  } state_t;

  // Idle timer only has to count up to TIMEOUT-1.
  localparam int TW =
    (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TLIM =
    (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [TW-1:0] TLAST = TW'(TLIM);
  localparam bit TO_EN = (TIMEOUT > 0);

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] base_d;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [ADDR_WIDTH-1:0] len_d;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] cnt_d;
  logic [ADDR_WIDTH-1:0] cnt_inc;
  logic [TW-1:0]         idle_q;
  logic [TW-1:0]         idle_d;
  logic                  we_q;
  logic                  we_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_d;

  logic accept;
  logic to_hit;
  logic last_word;

  // abort gates ready so a word offered with abort is never taken.
  assign s_ready   = (state_q == S_LOAD) & ~abort;
  assign accept    = s_valid & s_ready;
  assign cnt_inc   = cnt_q + 1'b1;
  assign last_word = (cnt_inc == len_q);
  assign to_hit    = TO_EN && (idle_q == TLAST);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      S_LOAD: begin
        if (abort) begin
          state_d = S_ERR;
        end else if (accept) begin
          // Accept beats a timeout in the same cycle.
          we_d   = 1'b1;
          addr_d = base_q + cnt_q;
          data_d = s_data;
          cnt_d  = cnt_inc;
          idle_d = '0;
          if (last_word) begin
            state_d = S_DONE;
          end
        end else if (to_hit) begin
          state_d = S_ERR;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          base_d = base_addr;
          len_d  = load_len;
          cnt_d  = '0;
          idle_d = '0;
          if (load_len == '0) begin
            state_d = S_ERR;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      idle_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign mem_we       = we_q;
  assign mem_cs       = we_q;
  assign mem_addr     = addr_q;
  assign mem_data     = data_q;
  assign load_busy    = (state_q == S_LOAD);
  assign load_done    = (state_q == S_DONE);
  assign load_err     = (state_q == S_ERR);
  // The last write lands in the first DONE cycle; the core's
  // first fetch is at least one cycle later.
  assign cpu_run      = (state_q == S_DONE);
  assign words_loaded = cnt_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// tb_imem_load_ctrl: directed scoreboard bench for imem_load_ctrl.
// Expected RAM writes are queued by stimulus and checked by a monitor.
module tb_imem_load_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] load_len = '0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_ready;
  logic        mem_cs;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        load_busy;
  logic        load_done;
  logic        load_err;
  logic        cpu_run;
  logic [15:0] words_loaded;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] exp_q[$];

  imem_load_ctrl #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(16),
    .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .base_addr(base_addr),
    .load_len(load_len),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_ready(s_ready),
    .mem_cs(mem_cs),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .load_busy(load_busy),
    .load_done(load_done),
    .load_err(load_err),
    .cpu_run(cpu_run),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm,
                     logic [31:0] act,
                     logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write on port 0 must match the head of the queue.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      chk("write_cs", {31'd0, mem_cs}, 32'd1);
      if (exp_q.size() == 0) begin
        chk("unexpected_write",
            {mem_addr, mem_data}, 32'hxxxx_xxxx);
      end else begin
        chk("write_addr_data",
            {mem_addr, mem_data}, exp_q.pop_front());
      end
    end
  end

  task automatic do_start(logic [15:0] b,
                          logic [15:0] l);
    start = 1'b1;
    base_addr = b;
    load_len = l;
    tick();
    start = 1'b0;
  endtask

  task automatic send(logic [15:0] a,
                      logic [15:0] d);
    s_valid = 1'b1;
    s_data = d;
    exp_q.push_back({a, d});
    tick();
    s_valid = 1'b0;
  endtask

  initial begin
    // Power-on reset
    tick();
    tick();
    rst = 1'b0;
    chk("rst_state",
        {load_busy, load_done, load_err, cpu_run,
         mem_we, mem_cs, s_ready}, 32'd0);
    chk("rst_regs", {mem_addr, words_loaded}, 32'd0);
    chk("rst_data", {16'd0, mem_data}, 32'd0);

    // T1: reset mid-stream drops the pending word
    do_start(16'h0050, 16'd4);
    chk("t1_busy", {31'd0, load_busy}, 32'd1);
    send(16'h0050, 16'hB001);
    s_valid = 1'b1;
    s_data = 16'hB002;
    rst = 1'b1;
    tick();
    chk("t1_rst1_we", {31'd0, mem_we}, 32'd0);
    chk("t1_rst1_st",
        {load_busy, load_done, load_err, cpu_run},
        32'd0);
    tick();
    rst = 1'b0;
    s_valid = 1'b0;
    chk("t1_rst2",
        {load_busy, load_done, load_err, cpu_run,
         mem_we, mem_cs}, 32'd0);
    chk("t1_wl", {16'd0, words_loaded}, 32'd0);

    // T2: normal 4-word load with valid held high
    do_start(16'h0010, 16'd4);
    chk("t2_run_lo", {31'd0, cpu_run}, 32'd0);
    send(16'h0010, 16'h00A1);
    chk("t2_ready", {31'd0, s_ready}, 32'd1);
    send(16'h0011, 16'h00A2);
    send(16'h0012, 16'h00A3);
    s_valid = 1'b1;
    send(16'h0013, 16'h00A4);
    s_valid = 1'b1;
    #1;
    chk("t2_ready_done", {31'd0, s_ready}, 32'd0);
    chk("t2_done", {30'd0, load_done, cpu_run}, 32'd3);
    chk("t2_wl", {16'd0, words_loaded}, 32'd4);
    tick();
    s_valid = 1'b0;
    chk("t2_hold", {16'd0, words_loaded}, 32'd4);

    // T3: timeout after 8 idle LOAD cycles
    do_start(16'h0100, 16'd3);
    send(16'h0100, 16'h0C01);
    for (int i = 0; i < 7; i++) tick();
    chk("t3_busy7", {31'd0, load_busy}, 32'd1);
    tick();
    chk("t3_err", {31'd0, load_err}, 32'd1);
    chk("t3_run", {31'd0, cpu_run}, 32'd0);
    chk("t3_wl", {16'd0, words_loaded}, 32'd1);

    // T4: address wrap
    do_start(16'hFFFE, 16'd4);
    send(16'hFFFE, 16'h1111);
    send(16'hFFFF, 16'h2222);
    send(16'h0000, 16'h3333);
    send(16'h0001, 16'h4444);
    chk("t4_done", {31'd0, load_done}, 32'd1);
    chk("t4_wl", {16'd0, words_loaded}, 32'd4);

    // T5: abort while word 3 is offered
    do_start(16'h0200, 16'd5);
    send(16'h0200, 16'h5001);
    send(16'h0201, 16'h5002);
    s_valid = 1'b1;
    s_data = 16'h5003;
    abort = 1'b1;
    #1;
    chk("t5_ready", {31'd0, s_ready}, 32'd0);
    tick();
    abort = 1'b0;
    s_valid = 1'b0;
    chk("t5_err", {31'd0, load_err}, 32'd1);
    chk("t5_wl", {16'd0, words_loaded}, 32'd2);
    tick();
    chk("t5_no_we", {31'd0, mem_we}, 32'd0);

    // T6: zero length, start while busy, restart from DONE
    do_start(16'h0000, 16'd0);
    chk("t6_len0", {30'd0, load_err, load_busy},
        32'd2);
    do_start(16'h0300, 16'd2);
    start = 1'b1;
    base_addr = 16'h0700;
    load_len = 16'd9;
    send(16'h0300, 16'h6001);
    start = 1'b0;
    send(16'h0301, 16'h6002);
    chk("t6_done", {31'd0, load_done}, 32'd1);
    chk("t6_wl", {16'd0, words_loaded}, 32'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t6_abort_ign", {31'd0, load_done}, 32'd1);
    do_start(16'h0400, 16'd1);
    chk("t6_restart",
        {30'd0, cpu_run, load_busy}, 32'd1);
    chk("t6_wl_clr", {16'd0, words_loaded}, 32'd0);
    send(16'h0400, 16'h7001);
    chk("t6_done2", {31'd0, cpu_run}, 32'd1);

    tick();
    tick();
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
